// File: rtl/enc_pkg.sv
// Shared constants and types for the HDC encoder datapath.
package enc_pkg;

  localparam int HV_DIM  = 4096;
  localparam int SHAMT_W = $clog2(HV_DIM);

  typedef logic [HV_DIM-1:0] hv_t;

endpackage

// File: rtl/hv_rotator.sv
// Combinational right-rotate of a hypervector by the amt bit-field [LSB +: NBITS],
// kept in place (i.e. the field is rotated by its weighted value, not shifted down).
module hv_rotator #(
  parameter int HV_DIM = 4096,
  parameter int LSB    = 0,
  parameter int NBITS  = $clog2(HV_DIM)
) (
  input  logic [HV_DIM-1:0]         hv,
  input  logic [$clog2(HV_DIM)-1:0] amt,
  output logic [HV_DIM-1:0]         rot
);

  localparam int SW = $clog2(HV_DIM);
  localparam logic [SW-1:0] AMT_MASK = SW'({NBITS{1'b1}}) << LSB;

  logic [SW-1:0] eff_s;

  // shifting the doubled vector right leaves the rotated word in the low half
  always_comb begin
    eff_s = amt & AMT_MASK;
    rot   = HV_DIM'({hv, hv} >> eff_s);
  end

endmodule

// File: rtl/enc_permuter.sv
// Streaming per-feature rotation stage: out_hv = level_hv rotated right by idx*SHIFT_STEP.
// Define ENC_PERM_PIPE_EN to split the rotation across two register stages.
module enc_permuter #(
  parameter int  HV_DIM       = enc_pkg::HV_DIM,
  parameter int  NUM_FEATURES = 617,
  parameter int  SHIFT_STEP   = 1,
  localparam int SHAMT_W      = $clog2(HV_DIM),
  localparam int IDX_W        = $clog2(NUM_FEATURES)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HV_DIM-1:0] level_hv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] out_hv,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last
);

  import enc_pkg::*;

  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_FEATURES - 1);
  localparam logic [SHAMT_W-1:0] STEP     = SHAMT_W'(SHIFT_STEP);

  logic [IDX_W-1:0]   idx_r;
  logic [SHAMT_W-1:0] shamt_r;
  logic               accept_s;
  logic               stage_ready_s;
  logic               out_load_s;
  logic [HV_DIM-1:0]  src_hv_s;
  logic [IDX_W-1:0]   src_idx_s;
  logic               out_valid_r;
  logic [HV_DIM-1:0]  out_hv_r;
  logic [IDX_W-1:0]   out_idx_r;
  logic               out_last_r;

  assign accept_s = in_valid && in_ready;
  assign in_ready = nrst && !clr && stage_ready_s;

  // Running feature index and its rotation amount (accumulated, no multiplier)
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx_r   <= '0;
      shamt_r <= '0;
    end else if (clr) begin
      idx_r   <= '0;
      shamt_r <= '0;
    end else if (accept_s) begin
      if (idx_r == IDX_LAST) begin
        idx_r   <= '0;
        shamt_r <= '0;
      end else begin
        idx_r   <= idx_r + IDX_W'(1);
        shamt_r <= shamt_r + STEP;
      end
    end
  end

`ifdef ENC_PERM_PIPE_EN
  localparam int LO_W = SHAMT_W / 2;
  localparam int HI_W = SHAMT_W - LO_W;

  logic               s1_valid_r;
  logic [HV_DIM-1:0]  s1_hv_r;
  logic [IDX_W-1:0]   s1_idx_r;
  logic [SHAMT_W-1:0] s1_shamt_r;
  logic [HV_DIM-1:0]  rot_lo_s;
  logic               s2_ready_s;

  hv_rotator #(.HV_DIM(HV_DIM), .LSB(0), .NBITS(LO_W)) u_rot_lo (
    .hv (level_hv),
    .amt(shamt_r),
    .rot(rot_lo_s)
  );

  hv_rotator #(.HV_DIM(HV_DIM), .LSB(LO_W), .NBITS(HI_W)) u_rot_hi (
    .hv (s1_hv_r),
    .amt(s1_shamt_r),
    .rot(src_hv_s)
  );

  assign s2_ready_s    = !out_valid_r || out_ready;
  assign stage_ready_s = !s1_valid_r || s2_ready_s;
  assign out_load_s    = s2_ready_s && s1_valid_r;
  assign src_idx_s     = s1_idx_r;

  // Stage 1: partially rotated beat plus the shamt needed to finish it
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_valid_r <= 1'b0;
      s1_hv_r    <= '0;
      s1_idx_r   <= '0;
      s1_shamt_r <= '0;
    end else if (clr) begin
      s1_valid_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_hv_r    <= rot_lo_s;
      s1_idx_r   <= idx_r;
      s1_shamt_r <= shamt_r;
    end else if (s2_ready_s) begin
      s1_valid_r <= 1'b0;
    end
  end
`else
  hv_rotator #(.HV_DIM(HV_DIM), .LSB(0), .NBITS(SHAMT_W)) u_rot (
    .hv (level_hv),
    .amt(shamt_r),
    .rot(src_hv_s)
  );

  assign stage_ready_s = !out_valid_r || out_ready;
  assign out_load_s    = accept_s;
  assign src_idx_s     = idx_r;
`endif

  // Output register: loads a new beat, holds while stalled, flush wins over out_ready
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_valid_r <= 1'b0;
      out_hv_r    <= '0;
      out_idx_r   <= '0;
      out_last_r  <= 1'b0;
    end else if (clr) begin
      out_valid_r <= 1'b0;
    end else if (out_load_s) begin
      out_valid_r <= 1'b1;
      out_hv_r    <= src_hv_s;
      out_idx_r   <= src_idx_s;
      out_last_r  <= (src_idx_s == IDX_LAST);
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign out_hv    = out_hv_r;
  assign out_idx   = out_idx_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_enc_permuter.sv
// Scoreboard bench for enc_permuter (HV_DIM=16, NUM_FEATURES=4, SHIFT_STEP=5).
module tb_enc_permuter;

  localparam int HV   = 16;
  localparam int NF   = 4;
  localparam int STEP = 5;
`ifdef ENC_PERM_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [15:0] hv;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] level_hv = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_hv;
  logic [1:0]  out_idx;
  logic        out_last;

  int   checks = 0;
  int   errors = 0;
  int   pop_cnt = 0;
  int   last_cnt = 0;
  int   m_idx = 0;
  int   m_sh = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  enc_permuter #(.HV_DIM(HV), .NUM_FEATURES(NF), .SHIFT_STEP(STEP)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .level_hv (level_hv),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_hv   (out_hv),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  function automatic logic [15:0] rot_model(input logic [15:0] hv, input int amt);
    logic [15:0] r;
    for (int j = 0; j < HV; j++) r[j] = hv[(j + amt) % HV];
    return r;
  endfunction

  // Scoreboard: push on acceptance, pop and compare on output handshake
  always @(negedge clk) begin
    exp_t e;
    if (!nrst || clr) begin
      sb_q.delete();
      m_idx = 0;
      m_sh  = 0;
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        pop_cnt++;
        if (out_last) last_cnt++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: unexpected beat hv=%h idx=%0d", out_hv, out_idx);
        end else begin
          e = sb_q.pop_front();
          if (out_hv !== e.hv || out_idx !== e.idx || out_last !== e.last) begin
            errors++;
            $display("FAIL sb_beat: got hv=%h idx=%0d last=%b, expected hv=%h idx=%0d last=%b",
                     out_hv, out_idx, out_last, e.hv, e.idx, e.last);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.hv   = rot_model(level_hv, m_sh);
        e.idx  = 2'(m_idx);
        e.last = (m_idx == NF - 1);
        sb_q.push_back(e);
        if (m_idx == NF - 1) begin
          m_idx = 0;
          m_sh  = 0;
        end else begin
          m_idx++;
          m_sh = (m_sh + STEP) % HV;
        end
      end
    end
  end

  task automatic send_beats(input int n, input logic [15:0] hv, input bit rnd_data,
                            input bit rnd_rdy, output int cycles);
    int sent = 0;
    cycles = 0;
    while (sent < n && cycles < 200) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      level_hv  = rnd_data ? 16'($urandom) : hv;
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cycles++;
      if (in_ready) sent++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (sent != n) begin
      errors++;
      $display("FAIL send_timeout: sent %0d beats, expected %0d", sent, n);
    end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb_q.size());
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    nrst = 1'b0; in_valid = 1'b1; level_hv = 16'h0001; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_hv !== 16'h0000 || out_idx !== 2'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b hv=%h idx=%0d last=%b, expected all 0",
               out_valid, out_hv, out_idx, out_last);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, expected 0", in_ready);
    end
    @(posedge clk); #1;
    nrst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready: got %b, expected 1", in_ready);
    end
    @(posedge clk); #1 in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != LAT) begin
      errors++;
      $display("FAIL first_latency: got %0d cycles, expected %0d", n, LAT);
    end
    checks++;
    if (out_hv !== 16'h0001 || out_idx !== 2'd0) begin
      errors++;
      $display("FAIL first_beat: got hv=%h idx=%0d, expected hv=0001 idx=0", out_hv, out_idx);
    end
    drain();
  endtask

  task automatic test_rotation();
    int cyc;
    int p0;
    pulse_clr();
    p0 = pop_cnt;
    send_beats(3, 16'h0001, 1'b0, 1'b0, cyc);
    drain();
    checks++;
    if (pop_cnt - p0 != 3) begin
      errors++;
      $display("FAIL rotation_count: got %0d beats, expected 3", pop_cnt - p0);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    int l0;
    pulse_clr();
    l0 = last_cnt;
    send_beats(6, 16'h0001, 1'b0, 1'b0, cyc);
    drain();
    checks++;
    if (last_cnt - l0 != 1) begin
      errors++;
      $display("FAIL wrap_last: got %0d last beats, expected 1", last_cnt - l0);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    send_beats(8, 16'h0000, 1'b1, 1'b0, cyc);
    checks++;
    if (cyc != 8) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d cycles for 8 beats, expected 8", cyc);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [15:0] hv_cap;
    logic [1:0]  idx_cap;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      level_hv  = 16'($urandom);
      out_ready = (i >= 3 && i < 6) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (i == 3) begin
        hv_cap  = out_hv;
        idx_cap = out_idx;
      end
      if (i >= 3 && i < 6) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_ready: got in_ready=%b out_valid=%b, expected 0/1", in_ready, out_valid);
        end
      end
      if (i >= 4 && i < 6) begin
        checks++;
        if (out_hv !== hv_cap || out_idx !== idx_cap) begin
          errors++;
          $display("FAIL bp_hold: got hv=%h idx=%0d, expected hv=%h idx=%0d",
                   out_hv, out_idx, hv_cap, idx_cap);
        end
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    drain();
  endtask

  task automatic test_flush();
    int n;
    int cyc;
    pulse_clr();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      level_hv  = 16'h0001;
      out_ready = 1'b1;
      clr       = (i == 2);
      @(negedge clk);
      if (i == 2) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL flush_in_ready: got %b, expected 0", in_ready);
        end
      end
    end
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: got %b, expected 0", out_valid);
    end
    send_beats(1, 16'h1234, 1'b0, 1'b0, cyc);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_hv !== 16'h1234 || out_idx !== 2'd0) begin
      errors++;
      $display("FAIL flush_restart: got v=%b hv=%h idx=%0d, expected v=1 hv=1234 idx=0",
               out_valid, out_hv, out_idx);
    end
    drain();
  endtask

  task automatic test_midreset();
    int cyc;
    send_beats(2, 16'h0000, 1'b1, 1'b0, cyc);
    @(posedge clk); #3 nrst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_hv !== 16'h0000 || out_idx !== 2'd0 ||
        out_last !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got v=%b hv=%h idx=%0d last=%b rdy=%b, expected all 0",
               out_valid, out_hv, out_idx, out_last, in_ready);
    end
    @(posedge clk); #1 nrst = 1'b1;
    send_beats(5, 16'h0000, 1'b1, 1'b0, cyc);
    drain();
  endtask

  task automatic test_random();
    bit          stall_prev = 1'b0;
    logic [15:0] hv_prev = 16'h0000;
    logic [1:0]  idx_prev = 2'd0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      level_hv  = 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_hv !== hv_prev || out_idx !== idx_prev) begin
          errors++;
          $display("FAIL rand_hold: got v=%b hv=%h idx=%0d, expected v=1 hv=%h idx=%0d",
                   out_valid, out_hv, out_idx, hv_prev, idx_prev);
        end
      end
      stall_prev = out_valid && !out_ready;
      hv_prev    = out_hv;
      idx_prev   = out_idx;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
